// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the sequential ALU. The
//                i_ signals travel from the issuing stage to the ALU, and
//                the o_ signals travel back.
//  Modports    : master - drives i_start/i_oprn/i_op1/i_op2, observes o_*
//                slave  - the ALU side (mirror of master)
//  Signals     : i_start  request, sampled only while the ALU is idle
//                i_oprn   opcode, latched with i_start
//                i_op1/2  operands, latched with i_start
//                o_out    result (low product half for multiply)
//                o_out_hi upper product half for multiply, else 0
//                o_zero   o_out == 0
//                o_ovf    signed overflow for add/sub
//                o_err    unsupported opcode
//                o_busy   operation in flight
//                o_done   one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
);
  logic                  i_start;
  logic [OPRN_WIDTH-1:0] i_oprn;
  logic [DATA_WIDTH-1:0] i_op1;
  logic [DATA_WIDTH-1:0] i_op2;
  logic [DATA_WIDTH-1:0] o_out;
  logic [DATA_WIDTH-1:0] o_out_hi;
  logic                  o_zero;
  logic                  o_ovf;
  logic                  o_err;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_start, i_oprn, i_op1, i_op2,
    input  o_out, o_out_hi, o_zero, o_ovf, o_err, o_busy, o_done
  );

  modport slave (
    input  i_start, i_oprn, i_op1, i_op2,
    output o_out, o_out_hi, o_zero, o_ovf, o_err, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with a START/DONE handshake. Single-cycle
//                operations complete one clock after START; multiply is an
//                iterative shift-add returning the full 2*DATA_WIDTH product.
//  Build macro : ALU_SEQ_MUL_EN - when defined, the shift-add multiplier
//                (MUL state, step counter, accumulator) is built and opcode
//                0x2c multiplies. When undefined, 0x2c is an unsupported
//                opcode (ERR, one-cycle latency).
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - alu_seq_if.slave (start/opcode/operands in,
//                        result/flags/busy/done out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int DATA_WIDTH = 32,  // power of two, >= 4
  parameter int OPRN_WIDTH = 6
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_seq_if.slave  bus
);

  localparam int c_SHW = $clog2(DATA_WIDTH);

  localparam logic [OPRN_WIDTH-1:0] c_OP_ADD = OPRN_WIDTH'(8'h20);
  localparam logic [OPRN_WIDTH-1:0] c_OP_SUB = OPRN_WIDTH'(8'h22);
  localparam logic [OPRN_WIDTH-1:0] c_OP_SHR = OPRN_WIDTH'(8'h02);
  localparam logic [OPRN_WIDTH-1:0] c_OP_SHL = OPRN_WIDTH'(8'h01);
  localparam logic [OPRN_WIDTH-1:0] c_OP_AND = OPRN_WIDTH'(8'h24);
  localparam logic [OPRN_WIDTH-1:0] c_OP_OR  = OPRN_WIDTH'(8'h25);
  localparam logic [OPRN_WIDTH-1:0] c_OP_NOR = OPRN_WIDTH'(8'h27);
  localparam logic [OPRN_WIDTH-1:0] c_OP_SLT = OPRN_WIDTH'(8'h2a);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [OPRN_WIDTH-1:0] c_OP_MUL = OPRN_WIDTH'(8'h2c);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_out_hi;
  logic                  r_zero;
  logic                  r_ovf;
  logic                  r_err;
  logic                  r_busy;
  logic                  r_done;

  // --------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs; its result is only
  // captured on the edge that accepts START, so it equals the latched view.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_dif;
  logic                  w_shamt_big;
  logic                  w_is_mul;

  assign w_sum = bus.i_op1 + bus.i_op2;
  assign w_dif = bus.i_op1 - bus.i_op2;
  // Any set bit above the log2(W) shift field means the shift clears everything.
  assign w_shamt_big = |bus.i_op2[DATA_WIDTH-1:c_SHW];

`ifdef ALU_SEQ_MUL_EN
  assign w_is_mul = (bus.i_oprn == c_OP_MUL);
`else
  assign w_is_mul = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (bus.i_oprn)
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.i_op1[DATA_WIDTH-1] == bus.i_op2[DATA_WIDTH-1]) &&
                (w_sum[DATA_WIDTH-1] != bus.i_op1[DATA_WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_dif;
        w_ovf = (bus.i_op1[DATA_WIDTH-1] != bus.i_op2[DATA_WIDTH-1]) &&
                (w_dif[DATA_WIDTH-1] != bus.i_op1[DATA_WIDTH-1]);
      end
      c_OP_SHR: w_res = w_shamt_big ? '0 : (bus.i_op1 >> bus.i_op2[c_SHW-1:0]);
      c_OP_SHL: w_res = w_shamt_big ? '0 : (bus.i_op1 << bus.i_op2[c_SHW-1:0]);
      c_OP_AND: w_res = bus.i_op1 & bus.i_op2;
      c_OP_OR:  w_res = bus.i_op1 | bus.i_op2;
      c_OP_NOR: w_res = ~(bus.i_op1 | bus.i_op2);
      c_OP_SLT: w_res = {{(DATA_WIDTH-1){1'b0}},
                         ($signed(bus.i_op1) < $signed(bus.i_op2))};
`ifdef ALU_SEQ_MUL_EN
      c_OP_MUL: w_res = '0;  // produced by the iterative path instead
`endif
      default:  w_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // --------------------------------------------------------------------------
  // Shift-add multiplier: acc_lo starts as the multiplier and fills with
  // product bits from the top as it is shifted out at the bottom.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_acc_hi;
  logic [DATA_WIDTH-1:0] r_acc_lo;
  logic [c_SHW-1:0]      r_cnt;
  logic [DATA_WIDTH:0]   w_step_sum;
  logic [DATA_WIDTH-1:0] w_nxt_hi;
  logic [DATA_WIDTH-1:0] w_nxt_lo;

  assign w_step_sum = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_mcand : '0)};
  // Shift {carry, sum, acc_lo} right by one.
  assign w_nxt_hi   = w_step_sum[DATA_WIDTH:1];
  assign w_nxt_lo   = {w_step_sum[0], r_acc_lo[DATA_WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_out    <= '0;
      r_out_hi <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_busy <= 1'b1;
            if (w_is_mul) begin
`ifdef ALU_SEQ_MUL_EN
              // Previous results stay visible until this product is ready.
              r_mcand  <= bus.i_op1;
              r_acc_hi <= '0;
              r_acc_lo <= bus.i_op2;
              r_cnt    <= c_SHW'(DATA_WIDTH-1);
              r_state  <= S_MUL;
`endif
            end else begin
              r_out    <= w_res;
              r_out_hi <= '0;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_err    <= w_err;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end
          end
        end
        S_MUL: begin
`ifdef ALU_SEQ_MUL_EN
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          if (r_cnt == '0) begin
            r_out    <= w_nxt_lo;
            r_out_hi <= w_nxt_hi;
            r_zero   <= (w_nxt_lo == '0);
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_cnt <= r_cnt - c_SHW'(1);
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_out    = r_out;
  assign bus.o_out_hi = r_out_hi;
  assign bus.o_zero   = r_zero;
  assign bus.o_ovf    = r_ovf;
  assign bus.o_err    = r_err;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq. A 32-bit instance runs a
//                directed vector table, hand-written handshake/reset
//                sequences and random operations against a behavioural
//                model; an 8-bit instance covers the narrow-width multiply
//                and shift boundary. Expectations follow ALU_SEQ_MUL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();
  alu_seq_if #(.DATA_WIDTH(8),  .OPRN_WIDTH(6)) bus8 ();

  alu_seq #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_seq #(.DATA_WIDTH(8),  .OPRN_WIDTH(6)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } res_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input res_t got, input res_t exp);
    chk({name, ".out"},  64'(got.out),  64'(exp.out));
    chk({name, ".hi"},   64'(got.hi),   64'(exp.hi));
    chk({name, ".zero"}, 64'(got.zero), 64'(exp.zero));
    chk({name, ".ovf"},  64'(got.ovf),  64'(exp.ovf));
    chk({name, ".err"},  64'(got.err),  64'(exp.err));
    chk({name, ".lat"},  64'(got.lat),  64'(exp.lat));
  endtask

  function automatic res_t mk_res(logic [31:0] out, logic [31:0] hi, logic zero,
                                  logic ovf, logic err, int lat);
    res_t r;
    r.out = out; r.hi = hi; r.zero = zero; r.ovf = ovf; r.err = err; r.lat = lat;
    return r;
  endfunction

  function automatic vec_t mk(string name, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                              res_t exp);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  // Behavioural reference: wide integer arithmetic, no bit-level datapath.
  function automatic res_t model(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    res_t   r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [63:0] p;
    r = mk_res(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    case (op)
      6'h20: begin s = sa + sb; r.out = 32'(s); r.ovf = (s != longint'($signed(r.out))); end
      6'h22: begin s = sa - sb; r.out = 32'(s); r.ovf = (s != longint'($signed(r.out))); end
      6'h02: r.out = (b >= 32) ? 32'd0 : (a >> b);
      6'h01: r.out = (b >= 32) ? 32'd0 : (a << b);
      6'h24: r.out = a & b;
      6'h25: r.out = a | b;
      6'h27: r.out = ~(a | b);
      6'h2a: r.out = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
      6'h2c: begin p = {32'd0, a} * {32'd0, b}; r.out = p[31:0]; r.hi = p[63:32]; r.lat = 33; end
`endif
      default: r.err = 1'b1;
    endcase
    r.zero = (r.out == 32'd0);
    return r;
  endfunction

  // Issue one request on the 32-bit instance; inputs are scrambled right after
  // the accepting edge so only latched copies can produce the result.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output res_t got);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_oprn = op; bus.i_op1 = a; bus.i_op2 = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0; bus.i_oprn = 6'($urandom); bus.i_op1 = $urandom; bus.i_op2 = $urandom;
    got.lat = 0;
    do begin
      @(negedge clk);
      got.lat++;
    end while (!bus.o_done && got.lat < 100);
    got.out = bus.o_out; got.hi = bus.o_out_hi; got.zero = bus.o_zero;
    got.ovf = bus.o_ovf; got.err = bus.o_err;
  endtask

  task automatic do_op8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                        output res_t got);
    @(negedge clk);
    bus8.i_start = 1'b1; bus8.i_oprn = op; bus8.i_op1 = a; bus8.i_op2 = b;
    @(posedge clk);
    #1;
    bus8.i_start = 1'b0; bus8.i_oprn = 6'($urandom); bus8.i_op1 = 8'($urandom); bus8.i_op2 = 8'($urandom);
    got.lat = 0;
    do begin
      @(negedge clk);
      got.lat++;
    end while (!bus8.o_done && got.lat < 100);
    got.out = {24'd0, bus8.o_out}; got.hi = {24'd0, bus8.o_out_hi}; got.zero = bus8.o_zero;
    got.ovf = bus8.o_ovf; got.err = bus8.o_err;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".out"},  64'(bus.o_out),    64'd0);
    chk({name, ".hi"},   64'(bus.o_out_hi), 64'd0);
    chk({name, ".zero"}, 64'(bus.o_zero),   64'd1);
    chk({name, ".ovf"},  64'(bus.o_ovf),    64'd0);
    chk({name, ".err"},  64'(bus.o_err),    64'd0);
    chk({name, ".busy"}, 64'(bus.o_busy),   64'd0);
    chk({name, ".done"}, 64'(bus.o_done),   64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    res_t        got;
    res_t        exp;
    logic [5:0]  ops[10];
    logic        seen;

    bus.i_start  = 1'b0; bus.i_oprn  = 6'h20; bus.i_op1  = '0; bus.i_op2  = '0;
    bus8.i_start = 1'b0; bus8.i_oprn = 6'h20; bus8.i_op1 = '0; bus8.i_op2 = '0;

    tbl.push_back(mk("add_ovf",  6'h20, 32'h7FFFFFFF, 32'd1,  mk_res(32'h80000000, 0, 0, 1, 0, 1)));
    tbl.push_back(mk("sub_zero", 6'h22, 32'd15, 32'd15,       mk_res(32'd0, 0, 1, 0, 0, 1)));
    tbl.push_back(mk("sub_ovf",  6'h22, 32'h80000000, 32'd1,  mk_res(32'h7FFFFFFF, 0, 0, 1, 0, 1)));
`ifdef ALU_SEQ_MUL_EN
    tbl.push_back(mk("mul",      6'h2c, 32'hFFFFFFFF, 32'd2,  mk_res(32'hFFFFFFFE, 1, 0, 0, 0, 33)));
`else
    tbl.push_back(mk("mul_off",  6'h2c, 32'hFFFFFFFF, 32'd2,  mk_res(32'd0, 0, 1, 0, 1, 1)));
`endif
    tbl.push_back(mk("shr",      6'h02, 32'd20, 32'd1,        mk_res(32'd10, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("shl",      6'h01, 32'd20, 32'd1,        mk_res(32'd40, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("shl_big",  6'h01, 32'd1, 32'd40,        mk_res(32'd0, 0, 1, 0, 0, 1)));
    tbl.push_back(mk("shr_31",   6'h02, 32'h80000000, 32'd31, mk_res(32'd1, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("shr_32",   6'h02, 32'h80000000, 32'd32, mk_res(32'd0, 0, 1, 0, 0, 1)));
    tbl.push_back(mk("nor_0",    6'h27, 32'd0, 32'd0,         mk_res(32'hFFFFFFFF, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("nor_1",    6'h27, 32'hFFFFFFFF, 32'hFFFFFFFF, mk_res(32'd0, 0, 1, 0, 0, 1)));
    tbl.push_back(mk("and",      6'h24, 32'hF0F0, 32'hFF00,   mk_res(32'hF000, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("or",       6'h25, 32'hF0F0, 32'hFF00,   mk_res(32'hFFF0, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("slt_neg",  6'h2a, 32'hFFFFFFFF, 32'd1,  mk_res(32'd1, 0, 0, 0, 0, 1)));
    tbl.push_back(mk("slt_pos",  6'h2a, 32'd10, 32'd1,        mk_res(32'd0, 0, 1, 0, 0, 1)));
    tbl.push_back(mk("bad_op",   6'h3F, 32'd5, 32'd6,         mk_res(32'd0, 0, 1, 0, 1, 1)));

    // Reset state, with a START held during reset that must be dropped.
    bus.i_start = 1'b1; bus.i_oprn = 6'h20; bus.i_op1 = 32'd1; bus.i_op2 = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset8.zero", 64'(bus8.o_zero), 64'd1);
    rst_n = 1'b1;
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("reset_start_dropped.busy", 64'(bus.o_busy), 64'd0);
    chk("reset_start_dropped.done", 64'(bus.o_done), 64'd0);

    // Directed table.
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, got);
      chk_res(tbl[i].name, got, tbl[i].exp);
    end

    // Reset in the middle of a multiply.
    do_op(6'h20, 32'd3, 32'd4, got);
    chk("pre_reset.out", 64'(got.out), 64'd7);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_oprn = 6'h2c; bus.i_op1 = 32'd7; bus.i_op2 = 32'd9;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_mul_reset");
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    chk("mid_mul_reset.no_done", 64'(seen), 64'd0);

    // START held high across a multiply: the next op goes in on the first IDLE cycle.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_oprn = 6'h2c; bus.i_op1 = 32'hFFFFFFFF; bus.i_op2 = 32'd2;
    @(posedge clk);
    #1;
    bus.i_oprn = 6'h20; bus.i_op1 = 32'd5; bus.i_op2 = 32'd6;
    got.lat = 0;
    do begin
      @(negedge clk);
      got.lat++;
    end while (!bus.o_done && got.lat < 100);
    got.out = bus.o_out; got.hi = bus.o_out_hi; got.zero = bus.o_zero;
    got.ovf = bus.o_ovf; got.err = bus.o_err;
    chk_res("hold_first", got, model(6'h2c, 32'hFFFFFFFF, 32'd2));
    @(negedge clk);
    chk("hold_idle.done", 64'(bus.o_done), 64'd0);
    chk("hold_idle.busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    chk("hold_second.done", 64'(bus.o_done), 64'd1);
    chk("hold_second.out",  64'(bus.o_out),  64'd11);
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("hold_after.busy", 64'(bus.o_busy), 64'd0);

    // Narrow instance.
`ifdef ALU_SEQ_MUL_EN
    do_op8(6'h2c, 8'd200, 8'd3, got);
    chk_res("w8_mul", got, mk_res(32'h58, 32'h02, 0, 0, 0, 9));
`else
    do_op8(6'h2c, 8'd200, 8'd3, got);
    chk_res("w8_mul_off", got, mk_res(32'h0, 32'h0, 1, 0, 1, 1));
`endif
    do_op8(6'h01, 8'd1, 8'd8, got);
    chk_res("w8_shl_big", got, mk_res(32'h0, 32'h0, 1, 0, 0, 1));
    do_op8(6'h20, 8'h7F, 8'd1, got);
    chk_res("w8_add_ovf", got, mk_res(32'h80, 32'h0, 0, 1, 0, 1));

    // Random operations against the model.
    ops = '{6'h20, 6'h22, 6'h2c, 6'h02, 6'h01, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2c};
    for (int i = 0; i < 150; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(0, 10) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 4))
        0:       a = 32'h7FFFFFFF;
        1:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      b = $urandom;
      if (op == 6'h01 || op == 6'h02) b = $urandom_range(0, 40);
      exp = model(op, a, b);
      do_op(op, a, b, got);
      chk_res($sformatf("rand%0d_op%0h", i, op), got, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 32-bit ALU: it executes the same opcode set on DATA_WIDTH-bit operands under a START/DONE handshake. Single-cycle operations return after one clock, and multiply runs as an iterative shift-add that also returns the upper half of the product. It sits between the register-file read stage and write-back in the processor datapath, and the control unit stalls on BUSY.

## Interface
- DATA_WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- OPRN_WIDTH, 6: opcode width.
- CLK input 1: clock; all state updates on the rising edge.
- RST input 1: synchronous, active-low reset, sampled on the CLK rising edge.
- START input 1: request; sampled only in IDLE.
- OPRN input OPRN_WIDTH: opcode; latched with START.
- OP1, OP2 input DATA_WIDTH: operands; latched with START.
- OUT output DATA_WIDTH: result; low half for multiply.
- OUT_HI output DATA_WIDTH: upper product half for multiply; 0 for all other ops.
- ZERO output 1: 1 iff OUT == 0.
- OVF output 1: signed overflow for add/sub; 0 for all other ops.
- ERR output 1: unsupported opcode.
- BUSY output 1: operation in flight; START ignored.
- DONE output 1: one-cycle pulse; OUT, OUT_HI, ZERO, OVF and ERR are valid from this cycle.

## Operation
- Opcodes:
  - 0x20 add: OP1+OP2 mod 2^W.
  - 0x22 sub: OP1-OP2 mod 2^W.
  - 0x2c mul: unsigned product, {OUT_HI,OUT}.
  - 0x02 shr: logical OP1>>OP2.
  - 0x01 shl: OP1<<OP2.
  - 0x24 and, 0x25 or, 0x27 nor: ~(OP1|OP2).
  - 0x2a slt: OUT = 1 if OP1 < OP2 as signed two's complement, else 0.
- Shift amount is the full OP2 value; OP2 ≥ DATA_WIDTH yields OUT = 0.
- OVF rules:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from OP1.
- Unsupported opcode: OUT = 0, OUT_HI = 0, ZERO = 1, ERR = 1; completes in one cycle.
- FSM states and transitions:
  - IDLE: on START, latch OP1/OP2/OPRN. A non-multiply opcode moves to FIN; a multiply moves to MUL.
  - MUL: one shift-add step per cycle, counter from DATA_WIDTH-1 down to 0; at 0, move to FIN.
  - FIN: register flags and result, pulse DONE, move to IDLE.
- Multiply step: if multiplier LSB is 1, add multiplicand into the upper accumulator with a carry bit; then shift {carry, acc_hi, acc_lo} right by 1.
- Results hold after DONE until the next accepted START.
- Operand and opcode inputs may change freely after the START cycle; only latched copies are used.

## Timing
- Reset (RST = 0 at an edge), from any state including mid-multiply:
  - state = IDLE, counter = 0.
  - OUT = 0, OUT_HI = 0, ZERO = 1, OVF = 0, ERR = 0, BUSY = 0, DONE = 0.
  - A START in the same cycle as reset is dropped.
- Non-multiply: START sampled at edge N; BUSY = 1 in cycle N+1, DONE = 1 in cycle N+1, back in IDLE at N+2. Latency is 1 cycle.
- Multiply: BUSY high for DATA_WIDTH+1 cycles; DONE in cycle N+DATA_WIDTH+1.
- BUSY is 1 in MUL and FIN; DONE is 1 only in FIN.
- START held high continuously is accepted again on the first IDLE cycle after DONE, so back-to-back ops issue every 2 cycles.
- START during BUSY is ignored, not queued.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL state, counter and accumulator are built; 0x2c behaves as above.
- ALU_SEQ_MUL_EN undefined: no multiplier logic; 0x2c is treated as unsupported (ERR = 1, one-cycle latency), and the FSM never enters MUL.

## Test plan
- Reset mid-multiply: START 0x2c, 7×9, assert RST at cycle 5 → outputs at reset values, BUSY = 0, no DONE pulse.
- Add/sub with overflow, W = 32:
  - 0x7FFFFFFF + 1 → OUT = 0x80000000, OVF = 1, DONE 1 cycle after START.
  - 15 - 15 → OUT = 0, ZERO = 1, OVF = 0.
- Multiply, W = 32: 0xFFFFFFFF × 2 → OUT = 0xFFFFFFFE, OUT_HI = 1, DONE exactly 33 cycles after START. With the macro off: ERR = 1 after 1 cycle.
- Shifts and logic:
  - 20 >> 1 = 10; 20 << 1 = 40; 1 << 40 = 0.
  - 0 nor 0 = 0xFFFFFFFF; 0xFFFFFFFF nor 0xFFFFFFFF = 0, ZERO = 1.
- slt signed: 0xFFFFFFFF slt 1 → 1; 10 slt 1 → 0; opcode 0x3F → ERR = 1, OUT = 0.
- Handshake: START held high across a multiply → the second START is ignored while BUSY; the next op is accepted in the first IDLE cycle. DATA_WIDTH = 8 build: 200 × 3 → OUT = 0x58, OUT_HI = 0x02, DONE after 9 cycles.
